// File: rtl/jtcop_pkg.sv
// Shared definitions for the jtcop object DMA and sprite engine.
// FSM encoding and default transfer geometry.
package jtcop_pkg;

  localparam int DMA_AW  = 10;
  localparam int DMA_LEN = 1024;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_GRANT = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    REQ   = S_REQ,
    GRANT = S_GRANT,
    READ  = S_READ,
    WRITE = S_WRITE,
    DONE  = S_DONE
  } dma_st_t;

endpackage

// File: rtl/jtcop_objdma.sv
// Sprite-table DMA: takes the 68000 bus, copies sprite RAM
// into the object buffer word by word, then returns the bus.
import jtcop_pkg::*;

module jtcop_objdma #(
  parameter int AW  = DMA_AW,
  parameter int LEN = DMA_LEN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dm_cs,
  input  logic          ASn,
  input  logic          BGn,
  output logic          BRn,
  output logic          BGACKn,
  output logic          busy,
  output logic          dma_cs,
  output logic [AW-1:0] dma_addr,
  input  logic [15:0]   dma_din,
  input  logic          dma_ok,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [15:0]   buf_dout
);

  localparam logic [AW:0] LAST = (AW+1)'(LEN-1);

  dma_st_t       st, st_nx;
  logic [AW:0]   cnt, cnt_nx, cnt_inc;
  logic          pend, pend_nx;
  logic          dm_l, trig;
  logic          brn_nx, bgackn_nx, busy_nx;
  logic          dma_cs_nx, buf_we_nx;
  logic [AW-1:0] dma_addr_nx, buf_addr_nx;
  logic [15:0]   buf_dout_nx;

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_l     <= 1'b0;
      trig     <= 1'b0;
      st       <= IDLE;
      cnt      <= '0;
      pend     <= 1'b0;
      BRn      <= 1'b1;
      BGACKn   <= 1'b1;
      busy     <= 1'b0;
      dma_cs   <= 1'b0;
      dma_addr <= '0;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      buf_dout <= '0;
    end else begin
      dm_l     <= dm_cs;
      trig     <= dm_cs & ~dm_l;
      st       <= st_nx;
      cnt      <= cnt_nx;
      pend     <= pend_nx;
      BRn      <= brn_nx;
      BGACKn   <= bgackn_nx;
      busy     <= busy_nx;
      dma_cs   <= dma_cs_nx;
      dma_addr <= dma_addr_nx;
      buf_we   <= buf_we_nx;
      buf_addr <= buf_addr_nx;
      buf_dout <= buf_dout_nx;
    end
  end

  // Outputs are computed one state ahead so every port is a flop
  always_comb begin
    st_nx       = st;
    cnt_nx      = cnt;
    pend_nx     = pend | (trig & (st != IDLE));
    brn_nx      = BRn;
    bgackn_nx   = BGACKn;
    busy_nx     = busy;
    dma_cs_nx   = dma_cs;
    dma_addr_nx = dma_addr;
    buf_we_nx   = 1'b0;
    buf_addr_nx = buf_addr;
    buf_dout_nx = buf_dout;
    unique case (st)
      IDLE: begin
        if (trig | pend) begin
          st_nx   = REQ;
          cnt_nx  = '0;
          pend_nx = 1'b0;
          busy_nx = 1'b1;
          brn_nx  = 1'b0;
        end
      end
      REQ: begin
        brn_nx = 1'b0;
        if (cen && !BGn && ASn && BGACKn)
          st_nx = GRANT;
      end
      GRANT: begin
        if (cen) begin
          bgackn_nx   = 1'b0;
          brn_nx      = 1'b1;
          st_nx       = READ;
          dma_cs_nx   = 1'b1;
          dma_addr_nx = cnt[AW-1:0];
        end
      end
      READ: begin
        if (dma_ok) begin
          buf_dout_nx = dma_din;
          buf_we_nx   = 1'b1;
          buf_addr_nx = cnt[AW-1:0];
          dma_cs_nx   = 1'b0;
          st_nx       = WRITE;
        end
      end
      WRITE: begin
        if (cnt == LAST) begin
          st_nx = DONE;
        end else begin
          cnt_nx      = cnt_inc;
          dma_cs_nx   = 1'b1;
          dma_addr_nx = cnt_inc[AW-1:0];
          st_nx       = READ;
        end
      end
      DONE: begin
        if (cen) begin
          bgackn_nx = 1'b1;
          if (pend) begin
            // a trigger arriving right now stays queued
            st_nx   = REQ;
            brn_nx  = 1'b0;
            cnt_nx  = '0;
            pend_nx = trig;
          end else begin
            st_nx   = IDLE;
            busy_nx = 1'b0;
          end
        end
      end
      default: st_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtcop_objdma.sv
// Directed bench for jtcop_objdma: a LEN=4 instance for the
// handshake cases and a LEN=1024 instance for the full copy.
module tb_jtcop_objdma;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
  logic ASn = 1'b1;

  logic        dm_cs0 = 1'b0, BGn0 = 1'b1;
  logic        BRn0, BGACKn0, busy0, dma_cs0, dma_ok0, buf_we0;
  logic [9:0]  dma_addr0, buf_addr0;
  logic [15:0] dma_din0, buf_dout0;

  logic        dm_cs1 = 1'b0, BGn1 = 1'b1;
  logic        BRn1, BGACKn1, busy1, dma_cs1, dma_ok1, buf_we1;
  logic [9:0]  dma_addr1, buf_addr1;
  logic [15:0] dma_din1, buf_dout1;

  logic [15:0] mem0 [4];
  int ws = 0, gnt = 3;
  int wc0 = 0, wc1 = 0, g0 = 0, g1 = 0;
  int w0 = 0, w1 = 0, base0 = 0, base1 = 0;
  int bad0 = 0, bad1 = 0, cs_cyc = 0, unstable = 0, overlap = 0;
  int last1 = 0;
  int n_chk = 0, n_fail = 0;
  logic [9:0] prev_addr0 = '0;
  logic prev_cs0 = 1'b0;

  always #5 clk = ~clk;

  assign dma_din0 = mem0[dma_addr0[1:0]];
  assign dma_din1 = {6'd0, dma_addr1} ^ 16'h5A5A;
  assign dma_ok0  = dma_cs0 && (wc0 > ws);
  assign dma_ok1  = dma_cs1 && (wc1 > ws);

  jtcop_objdma #(.AW(10), .LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dm_cs(dm_cs0),
    .ASn(ASn), .BGn(BGn0), .BRn(BRn0), .BGACKn(BGACKn0),
    .busy(busy0), .dma_cs(dma_cs0), .dma_addr(dma_addr0),
    .dma_din(dma_din0), .dma_ok(dma_ok0), .buf_we(buf_we0),
    .buf_addr(buf_addr0), .buf_dout(buf_dout0)
  );

  jtcop_objdma #(.AW(10), .LEN(1024)) u_full (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dm_cs(dm_cs1),
    .ASn(ASn), .BGn(BGn1), .BRn(BRn1), .BGACKn(BGACKn1),
    .busy(busy1), .dma_cs(dma_cs1), .dma_addr(dma_addr1),
    .dma_din(dma_din1), .dma_ok(dma_ok1), .buf_we(buf_we1),
    .buf_addr(buf_addr1), .buf_dout(buf_dout1)
  );

  // environment: monitors, bus arbiter, RAM wait states, cen
  initial forever begin
    @(negedge clk);
    if (buf_we0) begin
      if (int'(buf_addr0) != (w0 - base0) % 4 ||
          buf_dout0 != mem0[buf_addr0[1:0]])
        bad0++;
      w0++;
    end
    if (buf_we1) begin
      if (int'(buf_addr1) != (w1 - base1) % 1024 ||
          buf_dout1 != ({6'd0, buf_addr1} ^ 16'h5A5A))
        bad1++;
      last1 = int'(buf_addr1);
      w1++;
    end
    if (dma_cs0) cs_cyc++;
    if (dma_cs0 && prev_cs0 && dma_addr0 != prev_addr0)
      unstable++;
    prev_cs0 = dma_cs0;
    prev_addr0 = dma_addr0;
    if (!BRn0 && !BGACKn0) overlap++;
    if (!BRn1 && !BGACKn1) overlap++;
    if (BRn0) begin g0 = 0; BGn0 = 1'b1; end
    else if (cen) begin
      if (g0 >= gnt) BGn0 = 1'b0; else g0++;
    end
    if (BRn1) begin g1 = 0; BGn1 = 1'b1; end
    else if (cen) begin
      if (g1 >= gnt) BGn1 = 1'b0; else g1++;
    end
    wc0 = dma_cs0 ? wc0 + 1 : 0;
    wc1 = dma_cs1 ? wc1 + 1 : 0;
    cen = ~cen;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cen(input int n);
    repeat (n) begin
      do @(posedge clk); while (!cen);
    end
  endtask

  task automatic wait_idle(input int sel, input int budget,
                           input string tag);
    int n = 0;
    while ((sel == 1 ? busy1 : busy0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_wr(input int target, input int budget,
                         input string tag);
    int n = 0;
    while (w0 - base0 < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic pulse0();
    @(negedge clk) dm_cs0 = 1'b1;
    repeat (2) @(negedge clk);
    dm_cs0 = 1'b0;
  endtask

  initial begin
    mem0[0] = 16'h1111; mem0[1] = 16'h2222;
    mem0[2] = 16'h3333; mem0[3] = 16'h4444;
    repeat (4) @(negedge clk);
    chk("rst_brn", 32'(BRn0), 32'd1);
    chk("rst_bgack", 32'(BGACKn0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_dma", {31'd0, dma_cs0} | 32'(dma_addr0), 32'd0);
    chk("rst_buf", {31'd0, buf_we0} | 32'(buf_addr0), 32'd0);
    chk("rst_dout", 32'(buf_dout0), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single copy, zero-wait RAM
    base0 = w0; cs_cyc = 0;
    dm_cs0 = 1'b1;
    @(negedge clk);
    chk("trig_lat1", 32'(BRn0), 32'd1);
    @(negedge clk);
    chk("trig_lat2", 32'(BRn0), 32'd0);
    chk("busy_set", 32'(busy0), 32'd1);
    dm_cs0 = 1'b0;
    wait_idle(0, 300, "t1_done");
    chk("t1_writes", 32'(w0 - base0), 32'd4);
    chk("t1_data", 32'(bad0), 32'd0);
    chk("t1_cs_cyc", 32'(cs_cyc), 32'd4);
    chk("t1_bus", {30'd0, BRn0, BGACKn0}, 32'd3);

    // bus busy: grant held back while ASn low
    base0 = w0;
    ASn = 1'b0;
    pulse0();
    begin
      int n = 0;
      while (BGn0 && n < 100) begin @(negedge clk); n++; end
      chk("t2_grant", 32'(n < 100), 32'd1);
    end
    wait_cen(5); #1;
    chk("t2_hold", 32'(BGACKn0), 32'd1);
    @(negedge clk) ASn = 1'b1;
    wait_cen(1); #1;
    chk("t2_qual", 32'(BGACKn0), 32'd1);
    wait_cen(1); #1;
    chk("t2_bgack", {30'd0, BRn0, BGACKn0}, 32'd2);
    wait_idle(0, 300, "t2_done");
    chk("t2_writes", 32'(w0 - base0), 32'd4);

    // wait states: three extra clk per word
    ws = 3; base0 = w0; cs_cyc = 0; unstable = 0; bad0 = 0;
    pulse0();
    wait_idle(0, 400, "t3_done");
    chk("t3_writes", 32'(w0 - base0), 32'd4);
    chk("t3_cs_cyc", 32'(cs_cyc), 32'd16);
    chk("t3_stable", 32'(unstable), 32'd0);
    chk("t3_data", 32'(bad0), 32'd0);

    // retrigger twice during a copy collapses into one more
    base0 = w0; bad0 = 0;
    pulse0();
    wait_wr(1, 300, "t4_first");
    pulse0();
    repeat (3) @(negedge clk);
    pulse0();
    wait_idle(0, 800, "t4_done");
    chk("t4_writes", 32'(w0 - base0), 32'd8);
    chk("t4_data", 32'(bad0), 32'd0);
    repeat (100) @(negedge clk);
    chk("t4_quiet", 32'(w0 - base0) | 32'(busy0), 32'd8);

    // reset mid-copy
    base0 = w0;
    pulse0();
    wait_wr(2, 300, "t5_word2");
    #2 rst_n = 1'b0;
    #1;
    chk("t5_bus", {30'd0, BRn0, BGACKn0}, 32'd3);
    chk("t5_busy", 32'(busy0) | 32'(dma_cs0), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("t5_quiet", 32'(w0 - base0), 32'd2);
    chk("t5_idle", {30'd0, BRn0, busy0}, 32'd2);

    // full-size copy on the LEN=1024 instance
    ws = 0; base1 = w1;
    @(negedge clk) dm_cs1 = 1'b1;
    repeat (3) @(negedge clk);
    dm_cs1 = 1'b0;
    chk("t6_busy", 32'(busy1), 32'd1);
    wait_idle(1, 5000, "t6_done");
    chk("t6_writes", 32'(w1 - base1), 32'd1024);
    chk("t6_data", 32'(bad1), 32'd0);
    chk("t6_last", 32'(last1), 32'h3FF);
    repeat (50) @(negedge clk);
    chk("t6_quiet", 32'(w1 - base1), 32'd1024);
    chk("t6_bus", {30'd0, BRn1, BGACKn1}, 32'd3);
    chk("no_overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
